// File: rtl/zf_pkg.sv
// Shared definitions for the 2x2 zero-forcing inversion path.
package zf_pkg;

  localparam int W    = 32;
  localparam int FRAC = 16;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_t;

  localparam logic signed [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

endpackage

// File: rtl/adj_det_mac_sat_shift.sv
// Arithmetic right shift by FRAC followed by saturation from 2W+2 bits to W bits.
module sat_shift
  import zf_pkg::*;
#(
  parameter int W    = zf_pkg::W,
  parameter int FRAC = zf_pkg::FRAC
) (
  input  logic signed [2*W+1:0] acc,
  output logic signed [W-1:0]   res
);

  // Saturation limits of the W-bit result, sign-extended to accumulator width.
  localparam logic signed [2*W+1:0] HI = {{(W+3){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W+1:0] LO = {{(W+3){1'b1}}, {(W-1){1'b0}}};

  logic signed [2*W+1:0] shifted;

  // Shift toward minus infinity, then clamp into the signed W-bit range.
  always_comb begin
    shifted = acc >>> FRAC;
    if (shifted > HI) begin
      res = {1'b0, {(W-1){1'b1}}};
    end else if (shifted < LO) begin
      res = {1'b1, {(W-1){1'b0}}};
    end else begin
      res = shifted[W-1:0];
    end
  end

endmodule

// File: rtl/adj_det_mac.sv
// Determinant and adjugate-times-vector of a 2x2 matrix using one shared
// signed multiplier and a six-step time-multiplexed accumulator.
module adj_det_mac
  import zf_pkg::*;
#(
  parameter int W    = zf_pkg::W,
  parameter int FRAC = zf_pkg::FRAC
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  input  logic           accept_in,
  output logic           accept_out,
  output logic           ready_out,
  input  logic [4*W-1:0] mat,
  input  logic [2*W-1:0] zvec,
  output logic [2*W-1:0] vec,
  output logic [W-1:0]   el,
  output logic           det_zero
);

  state_t state, state_nx;
  logic [2:0] k;

  logic signed [W-1:0]   a_r, b_r, c_r, d_r, z0_r, z1_r;
  logic signed [W-1:0]   op_x, op_y;
  logic                  op_neg;
  logic signed [2*W-1:0] prod;
  logic signed [2*W+1:0] prod_ext, acc, acc_nx;
  logic signed [W-1:0]   cap;

  // Operand capture on acceptance.
  // NOTE: pure datapath registers, only read after a load, so they carry no reset.
  always_ff @(posedge clk) begin
    if (enable && accept_out && accept_in) begin
      a_r  <= mat[4*W-1:3*W];
      b_r  <= mat[3*W-1:2*W];
      c_r  <= mat[2*W-1:W];
      d_r  <= mat[W-1:0];
      z0_r <= zvec[2*W-1:W];
      z1_r <= zvec[W-1:0];
    end
  end

  // State register, frozen while enable is low.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else if (enable) begin
      state <= state_nx;
    end
  end

  // Next-state and handshake outputs.
  // NOTE: every output is defaulted first so no path through the case infers a latch.
  always_comb begin
    state_nx   = state;
    accept_out = 1'b0;
    ready_out  = 1'b0;
    case (state)
      IDLE: begin
        accept_out = 1'b1;
        if (accept_in) state_nx = MAC;
      end
      MAC: begin
        if (k == 3'd5) state_nx = OUT;
      end
      OUT: begin
        ready_out = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand mux: odd steps subtract and continue the even step's partial sum.
  always_comb begin
    op_x   = '0;
    op_y   = '0;
    op_neg = 1'b0;
    case (k)
      3'd0: begin op_x = a_r; op_y = d_r;  op_neg = 1'b0; end
      3'd1: begin op_x = b_r; op_y = c_r;  op_neg = 1'b1; end
      3'd2: begin op_x = d_r; op_y = z0_r; op_neg = 1'b0; end
      3'd3: begin op_x = b_r; op_y = z1_r; op_neg = 1'b1; end
      3'd4: begin op_x = a_r; op_y = z1_r; op_neg = 1'b0; end
      3'd5: begin op_x = c_r; op_y = z0_r; op_neg = 1'b1; end
      default: ;
    endcase
    prod     = op_x * op_y;
    prod_ext = {{2{prod[2*W-1]}}, prod};
    acc_nx   = (k[0] ? acc : '0) + (op_neg ? -prod_ext : prod_ext);
  end

  sat_shift #(
    .W    (W),
    .FRAC (FRAC)
  ) u_sat_shift (
    .acc (acc_nx),
    .res (cap)
  );

  // Step counter, accumulator and held result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k        <= '0;
      acc      <= '0;
      vec      <= '0;
      el       <= '0;
      det_zero <= 1'b0;
    end else if (enable) begin
      case (state)
        IDLE: begin
          if (accept_in) k <= '0;
        end
        MAC: begin
          acc <= acc_nx;
          k   <= (k == 3'd5) ? 3'd0 : 3'(k + 3'd1);
          case (k)
            3'd1: begin
              el       <= cap;
              det_zero <= (cap == '0);
            end
            3'd3: vec[2*W-1:W] <= cap;
            3'd5: vec[W-1:0]   <= cap;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adj_det_mac.sv
// Randomized scoreboard bench for adj_det_mac against a plain-arithmetic model.
module tb_adj_det_mac;
  import zf_pkg::*;

  typedef struct packed {
    logic [63:0] vec;
    logic [31:0] el;
    logic        dz;
  } exp_t;

  localparam logic [31:0] ONE = 32'h0001_0000;

  logic         clk = 1'b0;
  logic         reset, enable, accept_in;
  logic         accept_out, ready_out, det_zero;
  logic [127:0] mat;
  logic [63:0]  zvec, vec;
  logic [31:0]  el;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t exp_q[$];
  int   acc_t[$];

  always #5 clk = ~clk;

  adj_det_mac dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .accept_in  (accept_in),
    .accept_out (accept_out),
    .ready_out  (ready_out),
    .mat        (mat),
    .zvec       (zvec),
    .vec        (vec),
    .el         (el),
    .det_zero   (det_zero)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic signed [95:0] sx(input logic [31:0] v);
    return {{64{v[31]}}, v};
  endfunction

  // Q32.32 value -> Q16.16 by flooring shift, clamped to 32-bit signed.
  function automatic logic [31:0] to_q16(input logic signed [95:0] t);
    logic signed [95:0] s;
    s = t >>> 16;
    if (s > 96'sd2147483647) return 32'h7FFF_FFFF;
    if (s < -96'sd2147483648) return 32'h8000_0000;
    return s[31:0];
  endfunction

  function automatic exp_t model(input logic [127:0] m, input logic [63:0] z);
    logic signed [95:0] a, b, c, d, z0, z1;
    exp_t e;
    a  = sx(m[127:96]);
    b  = sx(m[95:64]);
    c  = sx(m[63:32]);
    d  = sx(m[31:0]);
    z0 = sx(z[63:32]);
    z1 = sx(z[31:0]);
    e.el  = to_q16(a * d - b * c);
    e.vec = {to_q16(d * z0 - b * z1), to_q16(a * z1 - c * z0)};
    e.dz  = (e.el == 32'h0);
    return e;
  endfunction

  // Acceptance logger: every request the DUT takes pushes its expected result.
  always @(posedge clk) begin
    if (!reset && enable && accept_in && accept_out) begin
      exp_q.push_back(model(mat, zvec));
      acc_t.push_back(cyc);
    end
    cyc++;
  end

  // Result monitor: compares once per enabled cycle with ready_out high.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset && enable && ready_out) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_ready actual=1 required=0 (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        check("el", 64'(el), 64'(e.el));
        check("vec", vec, e.vec);
        check("det_zero", 64'(det_zero), 64'(e.dz));
      end
    end
  end

  task automatic wait_idle();
    int guard = 0;
    @(negedge clk);
    while (!accept_out && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (!accept_out) check("accept_timeout", 64'(accept_out), 64'd1);
  endtask

  // Issue one request; lat counts cycles with the acceptance cycle as 1.
  task automatic run_req(input logic [127:0] m, input logic [63:0] z,
                         input int stall_at, input int stall_len, output int lat);
    wait_idle();
    mat       = m;
    zvec      = z;
    accept_in = 1'b1;
    @(posedge clk);
    #1 accept_in = 1'b0;
    lat = 1;
    while (lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == stall_at && stall_len > 0) begin
        enable = 1'b0;
        repeat (stall_len) begin
          @(posedge clk);
          #1;
          lat++;
        end
        enable = 1'b1;
      end
      if (ready_out) break;
    end
  endtask

  function automatic logic [31:0] rnd_val();
    if ($urandom_range(0, 3) == 0) return $urandom;
    return 32'($urandom_range(0, 32'h000F_FFFF)) - 32'h0008_0000;
  endfunction

  initial begin
    int lat, base, guard, st, sl;

    reset = 1'b1; enable = 1'b1; accept_in = 1'b0; mat = '0; zvec = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_accept_out", 64'(accept_out), 64'd1);
    check("rst_ready_out", 64'(ready_out), 64'd0);
    check("rst_vec", vec, 64'd0);
    check("rst_el", 64'(el), 64'd0);
    check("rst_det_zero", 64'(det_zero), 64'd0);
    @(negedge clk) reset = 1'b0;

    // Identity matrix, latency 7.
    run_req({ONE, 32'h0, 32'h0, ONE}, {32'h0002_0000, 32'h0003_0000}, 0, 0, lat);
    check("lat_identity", 64'(lat), 64'd7);
    // General and singular matrices.
    run_req({32'h0002_0000, ONE, ONE, ONE}, {ONE, ONE}, 0, 0, lat);
    run_req({ONE, ONE, ONE, ONE}, {ONE, 32'h0002_0000}, 0, 0, lat);
    // Saturation high then low.
    run_req({32'h7FFF_0000, 32'h0, 32'h0, 32'h7FFF_0000}, {ONE, ONE}, 0, 0, lat);
    run_req({32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 32'h0}, 64'h0, 0, 0, lat);

    // Three-cycle stall while k=2.
    run_req({32'h0003_0000, 32'h0001_8000, 32'hFFFF_0000, 32'h0002_0000},
            {32'h0001_4000, 32'hFFFE_0000}, 3, 3, lat);
    check("lat_stall", 64'(lat), 64'd10);

    // Requests while enable is low are ignored.
    @(posedge clk);
    #1 enable = 1'b0;
    mat = {ONE, ONE, ONE, 32'h0}; zvec = {ONE, ONE}; accept_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("disabled_no_accept", 64'(accept_out), 64'd1);
    accept_in = 1'b0;
    enable    = 1'b1;

    // accept_in held high: back-to-back acceptances.
    wait_idle();
    base = acc_t.size();
    mat = {ONE, 32'h0, 32'h0, ONE}; zvec = {ONE, 32'h0004_0000}; accept_in = 1'b1;
    guard = 0;
    while (acc_t.size() < base + 2 && guard < 40) begin
      @(posedge clk);
      #1 guard++;
    end
    accept_in = 1'b0;
    if (acc_t.size() >= base + 2)
      check("b2b_interval", 64'(acc_t[base+1] - acc_t[base]), 64'd8);
    else
      check("b2b_timeout", 64'(acc_t.size() - base), 64'd2);

    // Reset while k=3 discards the request and clears outputs.
    wait_idle();
    mat = {32'h0002_0000, ONE, 32'h0, 32'h0003_0000}; zvec = {ONE, ONE}; accept_in = 1'b1;
    @(posedge clk);
    #1 accept_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    exp_q.delete();
    check("mid_rst_accept_out", 64'(accept_out), 64'd1);
    check("mid_rst_vec", vec, 64'd0);
    check("mid_rst_el", 64'(el), 64'd0);
    check("mid_rst_ready", 64'(ready_out), 64'd0);
    @(negedge clk) reset = 1'b0;
    repeat (10) @(posedge clk);
    run_req({32'h0002_0000, ONE, 32'h0, 32'h0003_0000}, {ONE, ONE}, 0, 0, lat);
    check("lat_after_reset", 64'(lat), 64'd7);

    // Randomized requests with random stalls.
    for (int i = 0; i < 25; i++) begin
      st = $urandom_range(2, 7);
      sl = $urandom_range(0, 3);
      run_req({rnd_val(), rnd_val(), rnd_val(), rnd_val()}, {rnd_val(), rnd_val()}, st, sl, lat);
      check("lat_random", 64'(lat), 64'(7 + sl));
    end

    guard = 0;
    while (exp_q.size() != 0 && guard < 40) begin
      @(posedge clk);
      guard++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
